// File: rtl/sd_data_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sd_data_xfer_ctrl
// Purpose  : Multi-block SD data transfer sequencer. It issues one start_dat
//            command to the serial host per block and acknowledges each
//            completed block. A bad CRC or an abort ends the transfer with a
//            stop command. After the last write block it waits for the card
//            to release DAT0 busy.
// Ports    : sd_clk, rst            - clock, synchronous active-high reset
//            start_tx_i/start_rx_i  - one-cycle write/read requests
//            abort_i                - one-cycle abort request
//            blk_cnt_i, timeout_i   - block count and per-block timeout,
//                                     latched when a start is accepted
//            busy_n, transm_complete, crc_ok - status from the serial host
//            start_dat, ack_transfer - commands to the serial host
//            busy_o, done_o         - activity level and end-of-transfer pulse
//            err_*_o                - sticky error flags
//            blk_done_o             - blocks completed with good CRC
// Config   : define SD_DATA_TIMEOUT_EN to build the per-block timeout counter.
//            Without it, timeout_i is unused and err_timeout_o is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sd_data_xfer_ctrl #(
  parameter int TIMEOUT_W = 16,
  parameter int BLK_W     = 8
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 start_tx_i,
  input  logic                 start_rx_i,
  input  logic                 abort_i,
  input  logic [BLK_W-1:0]     blk_cnt_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 busy_n,
  input  logic                 transm_complete,
  input  logic                 crc_ok,
  output logic [1:0]           start_dat,
  output logic                 ack_transfer,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_crc_o,
  output logic                 err_timeout_o,
  output logic                 err_abort_o,
  output logic [BLK_W-1:0]     blk_done_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_ACTIVE    = 3'd2,
    S_ACK       = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_STOP      = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_dir_tx;
  logic [BLK_W-1:0] r_blk_cnt;
  logic             r_crc_ok;
  logic [BLK_W-1:0] w_blk_inc;
  logic             w_accept;
  logic             w_capture;
  logic             w_blk_good;
  logic             w_set_crc;
  logic             w_set_abort;
  logic             w_set_tmo;
  logic             w_tmo_hit;

  // Wraps modulo 2^BLK_W; only the equality test below ends a transfer.
  assign w_blk_inc = blk_done_o + BLK_W'(1);

`ifdef SD_DATA_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_timeout;
  logic [TIMEOUT_W-1:0] r_tmo_cnt;
  logic [TIMEOUT_W-1:0] w_tmo_cnt_inc;
  logic                 r_err_tmo;

  assign w_tmo_cnt_inc = r_tmo_cnt + TIMEOUT_W'(1);
  // The counter holds the number of ACTIVE cycles already elapsed, so the
  // limit is reached on the cycle whose increment would equal it.
  assign w_tmo_hit     = (r_state == S_ACTIVE) && (r_timeout != '0) &&
                         (w_tmo_cnt_inc == r_timeout);
  assign err_timeout_o = r_err_tmo;

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      r_timeout <= '0;
      r_tmo_cnt <= '0;
      r_err_tmo <= 1'b0;
    end else begin
      if (w_accept) begin
        r_timeout <= timeout_i;
        r_err_tmo <= 1'b0;
      end
      if (w_set_tmo) begin
        r_err_tmo <= 1'b1;
      end
      // Held at zero outside ACTIVE, so every entry starts a fresh count.
      if (r_state == S_ACTIVE) begin
        r_tmo_cnt <= w_tmo_cnt_inc;
      end else begin
        r_tmo_cnt <= '0;
      end
    end
  end
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^timeout_i;
  assign w_tmo_hit        = 1'b0;
  assign err_timeout_o    = 1'b0;
`endif

  // State register
  always_ff @(posedge sd_clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and datapath strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_blk_good  = 1'b0;
    w_set_crc   = 1'b0;
    w_set_abort = 1'b0;
    w_set_tmo   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_tx_i || start_rx_i) begin
          w_accept    = 1'b1;
          w_state_nxt = (blk_cnt_i == '0) ? S_DONE : S_START;
        end
      end
      S_START: begin
        if (abort_i) begin
          w_set_abort = 1'b1;
          w_state_nxt = S_STOP;
        end else begin
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // Abort beats a completing block; a completing block beats expiry.
        if (abort_i) begin
          w_set_abort = 1'b1;
          w_state_nxt = S_STOP;
        end else if (transm_complete) begin
          w_capture   = 1'b1;
          w_state_nxt = S_ACK;
        end else if (w_tmo_hit) begin
          w_set_tmo   = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
      S_ACK: begin
        if (abort_i) begin
          w_set_abort = 1'b1;
          w_state_nxt = S_STOP;
        end else if (!r_crc_ok) begin
          w_set_crc   = 1'b1;
          w_state_nxt = S_STOP;
        end else begin
          w_blk_good = 1'b1;
          if (w_blk_inc == r_blk_cnt) begin
            w_state_nxt = r_dir_tx ? S_WAIT_BUSY : S_DONE;
          end else begin
            w_state_nxt = S_START;
          end
        end
      end
      S_WAIT_BUSY: begin
        if (abort_i) begin
          w_set_abort = 1'b1;
          w_state_nxt = S_STOP;
        end else if (busy_n) begin
          w_state_nxt = S_DONE;
        end
      end
      S_STOP:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    start_dat    = 2'b00;
    ack_transfer = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      S_START: start_dat    = r_dir_tx ? 2'b01 : 2'b10;
      S_ACK:   ack_transfer = 1'b1;
      S_STOP:  start_dat    = 2'b11;
      S_DONE:  done_o       = 1'b1;
      default: start_dat    = 2'b00;
    endcase
  end

  assign busy_o = (r_state != S_IDLE);

  // Transfer context, block progress and sticky error flags
  always_ff @(posedge sd_clk) begin
    if (rst) begin
      r_dir_tx    <= 1'b0;
      r_blk_cnt   <= '0;
      r_crc_ok    <= 1'b0;
      blk_done_o  <= '0;
      err_crc_o   <= 1'b0;
      err_abort_o <= 1'b0;
    end else begin
      if (w_accept) begin
        r_dir_tx    <= start_tx_i;
        r_blk_cnt   <= blk_cnt_i;
        blk_done_o  <= '0;
        err_crc_o   <= 1'b0;
        err_abort_o <= 1'b0;
      end
      if (w_capture) begin
        r_crc_ok <= crc_ok;
      end
      if (w_blk_good) begin
        blk_done_o <= w_blk_inc;
      end
      if (w_set_crc) begin
        err_crc_o <= 1'b1;
      end
      if (w_set_abort) begin
        err_abort_o <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/sd_data_xfer_ctrl.md
SD_DATA_XFER_CTRL -- requirements
Module: sd_data_xfer_ctrl

Interface
REQ-001 Parameter TIMEOUT_W, default 16, width of the per-block transfer timeout counter.
REQ-002 Parameter BLK_W, default 8, width of the block count and block progress fields.
REQ-003 sd_clk  in  1  single clock; every register updates on its rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 start_tx_i  in  1  one-cycle request to begin a multi-block write.
REQ-006 start_rx_i  in  1  one-cycle request to begin a multi-block read.
REQ-007 abort_i  in  1  one-cycle request to abort the current transfer.
REQ-008 blk_cnt_i  in  BLK_W  number of blocks to move; sampled on the accepted start.
REQ-009 timeout_i  in  TIMEOUT_W  per-block timeout limit in sd_clk cycles; sampled on the accepted start.
REQ-010 busy_n  in  1  from the serial host; 0 while the card holds DAT0 busy.
REQ-011 transm_complete  in  1  from the serial host; one block has finished.
REQ-012 crc_ok  in  1  from the serial host; CRC status of the completed block, valid with transm_complete.
REQ-013 start_dat  out  2  to the serial host: 00 idle, 01 write, 10 read, 11 stop.
REQ-014 ack_transfer  out  1  to the serial host; acknowledges transm_complete.
REQ-015 busy_o  out  1  high in every state except IDLE.
REQ-016 done_o  out  1  one-cycle pulse when a transfer ends, whether successful or not.
REQ-017 err_crc_o, err_timeout_o, err_abort_o  out  1 each  sticky error flags.
REQ-018 blk_done_o  out  BLK_W  count of blocks completed with good CRC.

Function
REQ-019 State set: IDLE, START, ACTIVE, ACK, WAIT_BUSY, STOP, DONE.
REQ-020 IDLE:
- start_tx_i has priority over start_rx_i when both are high.
- On an accepted start: latch direction, blk_cnt_i and timeout_i; clear all error flags and blk_done_o; go to START.
- Exception: blk_cnt_i=0 goes straight to DONE, with no start_dat activity.
REQ-021 START: drive start_dat=01 (tx) or 10 (rx) for exactly one cycle, then go to ACTIVE.
REQ-022 ACTIVE:
- Hold start_dat=00.
- On transm_complete=1, capture crc_ok and go to ACK.
REQ-023 ACK: assert ack_transfer for exactly one cycle.
- If the captured CRC is bad: set err_crc_o and go to STOP.
- If the CRC is good: increment blk_done_o. If blk_done_o now equals the latched count, go to WAIT_BUSY (tx) or DONE (rx); otherwise go to START.
REQ-024 WAIT_BUSY: remain until busy_n=1, then go to DONE.
REQ-025 STOP: drive start_dat=11 for exactly one cycle, then go to DONE.
REQ-026 DONE: pulse done_o for one cycle, then go to IDLE.
REQ-027 ack_transfer is 0 in every state other than ACK.
REQ-028 abort_i=1 in START, ACTIVE, ACK or WAIT_BUSY:
- sets err_abort_o and goes to STOP on the next edge;
- overrides a transm_complete arriving in the same cycle, so blk_done_o is not incremented.
REQ-029 abort_i in IDLE, STOP or DONE is ignored.
REQ-030 start_tx_i and start_rx_i are ignored outside IDLE.
REQ-031 blk_done_o wraps modulo 2^BLK_W, and only the equality comparison in REQ-023 terminates the transfer.
REQ-032 Latency from an accepted start to start_dat≠00 is 1 cycle.

Reset
REQ-033 rst=1 forces IDLE on the next edge and applies these values: start_dat=00, ack_transfer=0, busy_o=0, done_o=0, all error flags 0, blk_done_o=0, timeout counter 0.
REQ-034 Reset mid-transfer abandons the transfer without issuing start_dat=11 and without a done_o pulse.
REQ-035 rst has priority over every other input.

Configuration
REQ-036 Macro SD_DATA_TIMEOUT_EN, when defined, enables the per-block timeout:
- the counter clears on entry to ACTIVE and increments each cycle in ACTIVE;
- on reaching the latched timeout_i without transm_complete, set err_timeout_o and go to STOP;
- transm_complete in the same cycle as expiry wins, and no timeout is flagged;
- timeout_i=0 disables the check.
REQ-037 Without SD_DATA_TIMEOUT_EN: no counter logic is present, timeout_i is unused, err_timeout_o is tied to 0, and ACTIVE waits indefinitely.

Verification
REQ-038 Good write: blk_cnt_i=3, start_tx_i, each transm_complete with crc_ok=1, busy_n low for 20 cycles after block 3 -> three start_dat=01 pulses, three ack_transfer pulses, blk_done_o=3, done_o 1 cycle after busy_n rises, no errors.
REQ-039 CRC fail on read: blk_cnt_i=4, start_rx_i, block 2 with crc_ok=0 -> blk_done_o=1, err_crc_o=1, one start_dat=11 cycle, then done_o.
REQ-040 Timeout (macro defined): timeout_i=100, no transm_complete -> err_timeout_o set 100 cycles after entering ACTIVE, start_dat=11, then done_o; without the macro -> stays in ACTIVE.
REQ-041 Abort coincident with transm_complete in ACTIVE -> err_abort_o=1, blk_done_o unchanged, STOP, then done_o.
REQ-042 Simultaneous start_tx_i and start_rx_i with blk_cnt_i=0 -> done_o the next cycle, start_dat stays 00; then a new start with blk_cnt_i=1 begins a write.
REQ-043 rst asserted for 1 cycle during ACTIVE -> all outputs at reset values, no start_dat=11, no done_o.
